// File: rtl/async_event_arbiter.sv
// async_event_arbiter
// Conditions N_INPUTS asynchronous single-bit inputs into clean clk_in-domain
// rising-edge events, then shares one registered event channel among them.
// Each channel runs: synchronizer -> debounce counter -> rising-edge detect
// -> sticky pending flag. A round-robin arbiter drains the pending flags.
//
// Ports:
//   clk_in        system clock, all logic on posedge
//   rst_in        synchronous active-high reset
//   us_in         raw asynchronous inputs
//   level_out     debounced levels
//   event_valid   event_id holds a granted rising-edge event
//   event_id      channel index of the presented event
//   event_ready   consumer accept strobe
//   overflow      sticky per-channel "edge dropped while already pending"
//   overflow_clr  per-bit clear pulse for overflow
//
// Handshake: an event transfers on a posedge where event_valid && event_ready.
// While event_valid && !event_ready, event_valid and event_id hold unchanged.
// event_valid and event_id are registered; event_ready only steers the next
// register update and never reaches the outputs combinationally.

// Multi-stage flip-flop synchronizer; on reset every stage loads the input.
module synchronizer #(
   parameter int DEPTH = 2
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic d,
   output logic q
);
   logic [DEPTH-1:0] stages;

   always_ff @(posedge clk_in) begin
      if (rst_in) stages <= {DEPTH{d}};
      else        stages <= {stages[DEPTH-2:0], d};
   end

   assign q = stages[DEPTH-1];
endmodule

module async_event_arbiter #(
   parameter int N_INPUTS        = 4,
   parameter int SYNC_DEPTH      = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic [N_INPUTS-1:0]         us_in,
   output logic [N_INPUTS-1:0]         level_out,
   output logic                        event_valid,
   output logic [$clog2(N_INPUTS)-1:0] event_id,
   input  logic                        event_ready,
   output logic [N_INPUTS-1:0]         overflow,
   input  logic [N_INPUTS-1:0]         overflow_clr
);
   localparam int ID_W  = $clog2(N_INPUTS);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [ID_W-1:0]  LAST_RESET = ID_W'(N_INPUTS - 1);

   logic [N_INPUTS-1:0] sync_lvl;
   logic [CNT_W-1:0]    deb_cnt [N_INPUTS];
   logic [N_INPUTS-1:0] prev_level;
   logic [N_INPUTS-1:0] rise;
   logic [N_INPUTS-1:0] pending;
   logic [ID_W-1:0]     last_grant;

   logic                slot_free;
   logic                grant_found;
   logic [ID_W-1:0]     grant_idx;
   logic [N_INPUTS-1:0] grant_mask;
   int                  scan_idx;

   for (genvar g = 0; g < N_INPUTS; g++) begin : g_sync
      synchronizer #(.DEPTH(SYNC_DEPTH)) u_sync (
         .clk_in (clk_in),
         .rst_in (rst_in),
         .d      (us_in[g]),
         .q      (sync_lvl[g])
      );
   end

   // Any cycle where the synchronized value agrees with the level restarts
   // the count, so only a run of DEBOUNCE_CYCLES disagreeing cycles flips it.
   always_ff @(posedge clk_in) begin
      for (int i = 0; i < N_INPUTS; i++) begin
         if (rst_in) begin
            level_out[i] <= 1'b0;
            deb_cnt[i]   <= '0;
         end else if (sync_lvl[i] == level_out[i]) begin
            deb_cnt[i] <= '0;
         end else if (deb_cnt[i] == CNT_MAX) begin
            level_out[i] <= sync_lvl[i];
            deb_cnt[i]   <= '0;
         end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
         end
      end
   end

   assign rise      = level_out & ~prev_level;
   assign slot_free = !event_valid || event_ready;

   // Round-robin search starting just after the last granted channel.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      grant_mask  = '0;
      scan_idx    = 0;
      for (int k = 1; k <= N_INPUTS; k++) begin
         scan_idx = (int'(last_grant) + k) % N_INPUTS;
         if (!grant_found && pending[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = ID_W'(scan_idx);
         end
      end
      if (slot_free && grant_found) grant_mask[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         prev_level  <= '0;
         pending     <= '0;
         overflow    <= '0;
         last_grant  <= LAST_RESET;
         event_valid <= 1'b0;
         event_id    <= '0;
      end else begin
         prev_level <= level_out;
         // A new edge on the channel being granted re-arms it (set wins);
         // a new edge on a channel still waiting is dropped and flagged.
         pending  <= (pending & ~grant_mask) | rise;
         overflow <= (overflow & ~overflow_clr) | (rise & pending & ~grant_mask);
         if (slot_free) begin
            event_valid <= grant_found;
            if (grant_found) begin
               event_id   <= grant_idx;
               last_grant <= grant_idx;
            end
         end
      end
   end
endmodule

// File: tb/tb_async_event_arbiter.sv
// Testbench for async_event_arbiter (N_INPUTS=4, SYNC_DEPTH=2,
// DEBOUNCE_CYCLES=4). A behavioural model tracks expected outputs every
// cycle; directed sequences and a vector table add explicit expectations.
module tb_async_event_arbiter;
   localparam int N   = 4;
   localparam int D   = 2;
   localparam int DEB = 4;
   localparam int IW  = 2;
   localparam int EW  = N + 1 + IW + N;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  us;
   logic [N-1:0]  level_out;
   logic          event_valid;
   logic [IW-1:0] event_id;
   logic          ready;
   logic [N-1:0]  overflow;
   logic [N-1:0]  clr;

   int checks = 0;
   int errors = 0;
   int ev_cnt = 0;
   logic [IW-1:0] last_ev_id = '0;

   always #5 clk = ~clk;

   async_event_arbiter #(.N_INPUTS(N), .SYNC_DEPTH(D), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk_in       (clk),
      .rst_in       (rst),
      .us_in        (us),
      .level_out    (level_out),
      .event_valid  (event_valid),
      .event_id     (event_id),
      .event_ready  (ready),
      .overflow     (overflow),
      .overflow_clr (clr)
   );

   // ---------------- reference model ----------------
   logic [N-1:0]  m_lvl, m_armed, m_pend, m_ovf;
   int            m_run [N];
   bit            m_valid;
   int            m_id, m_last;
   logic [N-1:0]  m_dly[$];
   logic [EW-1:0] exp_q[$];

   always @(posedge clk) begin : model
      logic [N-1:0] s, pend_before, ovf_set;
      int granted, c;
      if (rst) begin
         m_lvl = '0; m_armed = '0; m_pend = '0; m_ovf = '0;
         m_valid = 0; m_id = 0; m_last = N - 1;
         for (int i = 0; i < N; i++) m_run[i] = 0;
         m_dly.delete();
         for (int j = 0; j < D; j++) m_dly.push_back(us);
      end else begin
         s = m_dly[0];
         granted = -1;
         pend_before = m_pend;
         ovf_set = '0;
         if (!m_valid || ready) begin
            m_valid = 0;
            for (int k = 1; k <= N; k++) begin
               c = (m_last + k) % N;
               if (granted < 0 && m_pend[c]) granted = c;
            end
            if (granted >= 0) begin
               m_valid = 1; m_id = granted; m_last = granted; m_pend[granted] = 1'b0;
            end
         end
         for (int i = 0; i < N; i++) begin
            if (m_armed[i]) begin
               if (pend_before[i] && i != granted) ovf_set[i] = 1'b1;
               else m_pend[i] = 1'b1;
            end
         end
         m_ovf = (m_ovf & ~clr) | ovf_set;
         m_armed = '0;
         for (int i = 0; i < N; i++) begin
            if (s[i] != m_lvl[i]) begin
               m_run[i]++;
               if (m_run[i] == DEB) begin
                  m_lvl[i] = s[i];
                  m_run[i] = 0;
                  m_armed[i] = s[i];
               end
            end else begin
               m_run[i] = 0;
            end
         end
         void'(m_dly.pop_front());
         m_dly.push_back(us);
      end
      exp_q.push_back({m_lvl, m_valid, IW'(m_id), m_ovf});
   end

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin : scoreboard
      logic [EW-1:0] e, act;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         act = {level_out, event_valid, event_id, overflow};
         checks++;
         if (act !== e) begin
            errors++;
            $display("FAIL model_cycle t=%0t: got %h expected %h", $time, act, e);
         end
      end
      if (event_valid === 1'b1) begin
         ev_cnt++;
         last_ev_id = event_id;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; us = '0; ready = 1'b0; clr = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (event_valid !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'd0, event_valid}, 32'd1);
   endtask

   task automatic wait_level(input int ch, input logic val, input string name);
      int n = 0;
      while (level_out[ch] !== val && n < 30) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'd0, level_out[ch]}, {31'd0, val});
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [N-1:0]  us;
      logic          ready;
      logic [N-1:0]  lvl;
      logic          valid;
      logic [IW-1:0] id;
   } vec_t;
   vec_t vecs [16];

   initial begin
      int c0, seen;
      rst = 1'b1; us = '0; ready = 1'b0; clr = '0;

      // clean edge on channel 2, then release
      for (int r = 0; r < 16; r++) begin
         vecs[r].us    = (r < 9) ? 4'b0100 : 4'b0000;
         vecs[r].ready = 1'b1;
         vecs[r].lvl   = (r >= 5 && r < 14) ? 4'b0100 : 4'b0000;
         vecs[r].valid = (r == 7);
         vecs[r].id    = (r >= 7) ? 2'd2 : 2'd0;
      end

      do_reset();
      check("reset_level", {28'd0, level_out}, 32'd0);
      check("reset_valid", {31'd0, event_valid}, 32'd0);
      check("reset_ovf", {28'd0, overflow}, 32'd0);
      for (int r = 0; r < 16; r++) begin
         us = vecs[r].us;
         ready = vecs[r].ready;
         @(negedge clk);
         check($sformatf("vec%0d", r),
               {25'd0, level_out, event_valid, event_id},
               {25'd0, vecs[r].lvl, vecs[r].valid, vecs[r].id});
      end

      // bounce on channel 1
      do_reset();
      ready = 1'b1;
      c0 = ev_cnt;
      us[1] = 1'b1; repeat (3) @(negedge clk);
      us[1] = 1'b0; repeat (1) @(negedge clk);
      us[1] = 1'b1; repeat (2) @(negedge clk);
      us[1] = 1'b0; repeat (10) @(negedge clk);
      check("bounce_level", {28'd0, level_out}, 32'd0);
      check("bounce_events", ev_cnt - c0, 32'd0);
      check("bounce_ovf", {28'd0, overflow}, 32'd0);
      us[1] = 1'b1; repeat (15) @(negedge clk);
      check("bounce_then_stable_events", ev_cnt - c0, 32'd1);
      check("bounce_then_stable_id", {30'd0, last_ev_id}, 32'd1);

      // round robin under stall
      do_reset();
      us = 4'b1001;
      wait_valid("rr_first_valid");
      check("rr_first_id", {30'd0, event_id}, 32'd0);
      repeat (3) @(negedge clk);
      check("rr_held", {29'd0, event_valid, event_id}, {29'd0, 1'b1, 2'd0});
      ready = 1'b1; @(negedge clk);
      check("rr_second", {29'd0, event_valid, event_id}, {29'd0, 1'b1, 2'd3});
      @(negedge clk);
      check("rr_drained", {31'd0, event_valid}, 32'd0);
      ready = 1'b0; us = '0;
      repeat (10) @(negedge clk);
      us = 4'b1001;
      wait_valid("rr_repeat_valid");
      check("rr_repeat_first_id", {30'd0, event_id}, 32'd0);
      ready = 1'b1; @(negedge clk);
      check("rr_repeat_second", {29'd0, event_valid, event_id}, {29'd0, 1'b1, 2'd3});
      ready = 1'b0;

      // overflow on channel 1
      do_reset();
      for (int p = 0; p < 3; p++) begin
         us[1] = 1'b1; repeat (7) @(negedge clk);
         us[1] = 1'b0; repeat (7) @(negedge clk);
      end
      check("ovf_third_edge", {28'd0, overflow}, 32'h2);
      check("ovf_held_event", {29'd0, event_valid, event_id}, {29'd0, 1'b1, 2'd1});
      clr = 4'b0010; @(negedge clk); clr = '0;
      check("ovf_cleared", {28'd0, overflow}, 32'd0);
      us[1] = 1'b1;
      wait_level(1, 1'b1, "ovf_fourth_level");
      clr = 4'b0010; @(negedge clk); clr = '0;
      check("ovf_set_beats_clr", {28'd0, overflow}, 32'h2);
      us[1] = 1'b0; ready = 1'b1;
      repeat (12) @(negedge clk);

      // set/grant collision on channel 2
      do_reset();
      us = 4'b0101;
      wait_valid("coll_first_valid");
      check("coll_first_id", {30'd0, event_id}, 32'd0);
      us[2] = 1'b0;
      wait_level(2, 1'b0, "coll_fall");
      repeat (2) @(negedge clk);
      us[2] = 1'b1;
      wait_level(2, 1'b1, "coll_rise");
      ready = 1'b1; @(negedge clk);
      check("coll_grant_a", {29'd0, event_valid, event_id}, {29'd0, 1'b1, 2'd2});
      @(negedge clk);
      check("coll_grant_b", {29'd0, event_valid, event_id}, {29'd0, 1'b1, 2'd2});
      @(negedge clk);
      check("coll_done", {31'd0, event_valid}, 32'd0);
      check("coll_ovf", {28'd0, overflow}, 32'd0);

      // reset mid-operation
      do_reset();
      us = 4'b0101;
      wait_valid("mid_valid");
      repeat (2) @(negedge clk);
      rst = 1'b1; us = 4'b0001;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_state", {23'd0, level_out, event_valid, overflow}, 32'd0);
      c0 = ev_cnt; ready = 1'b1;
      repeat (12) @(negedge clk);
      check("mid_rst_events", ev_cnt - c0, 32'd1);
      check("mid_rst_id", {30'd0, last_ev_id}, 32'd0);

      // random traffic against the model
      do_reset();
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(negedge clk);
         if ($urandom_range(0, 7) == 0) us[$urandom_range(0, N - 1)] ^= 1'b1;
         ready = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 15)) : '0;
         rst = ($urandom_range(0, 299) == 0);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      seen = checks;
      check("checks_made", {31'd0, seen > 1000}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/async_event_arbiter.md
Name: async_event_arbiter

Overview:
- Conditions N asynchronous single-bit inputs (buttons, switches, external strobes) into clean clk_in-domain events and shares one event output channel among them.
- Per channel: N_INPUTS instances of the team's existing `synchronizer` module (SYNC_DEPTH stages), then a debounce counter, then a rising-edge detector, then a sticky pending flag.
- A round-robin arbiter drains the pending flags into a single valid/ready event stream consumed by downstream control FSMs.

Parameters:
- N_INPUTS, 4, number of asynchronous input channels (2..16).
- SYNC_DEPTH, 2, flip-flop stages in each per-channel synchronizer instance (>=2).
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized value must differ from the debounced level before the level flips (>=2). Counter width is $clog2(DEBOUNCE_CYCLES).

Ports:
- clk_in  input  1  single system clock; all logic on posedge.
- rst_in  input  1  synchronous, active-high reset.
- us_in  input  N_INPUTS  raw asynchronous inputs.
- level_out  output  N_INPUTS  debounced levels.
- event_valid  output  1  event_id holds a granted rising-edge event.
- event_id  output  $clog2(N_INPUTS)  channel index of the presented event.
- event_ready  input  1  consumer accepts the event when event_valid && event_ready.
- overflow  output  N_INPUTS  sticky flag: an edge was dropped because that channel was already pending.
- overflow_clr  input  N_INPUTS  per-bit clear pulse for overflow.

Behaviour:
- Reset values:
  - level_out=0, event_valid=0, event_id=0, overflow=0.
  - All pending flags and debounce counters are 0.
  - Round-robin pointer last_grant=N_INPUTS-1, so channel 0 has first priority after reset.
  - Synchronizer chains load us_in, as the existing module does.
- Debounce, per channel, with s = synchronizer output:
  - If s==level: counter<=0.
  - Else, if counter==DEBOUNCE_CYCLES-1: level<=s and counter<=0.
  - Else: counter<=counter+1.
  - Any cycle with s==level restarts the count, so a glitch shorter than DEBOUNCE_CYCLES is invisible.
- Latency: input stable before edge E0 gives level_out change after edge E0+SYNC_DEPTH+DEBOUNCE_CYCLES-1.
- Edge detect:
  - Rising edge: level_out 0->1 (registered previous level). It sets pending[i] on the following edge.
  - Falling edges update level_out only and generate no event.
- Event latency: event_valid asserts after edge E0+SYNC_DEPTH+DEBOUNCE_CYCLES+1, provided the output slot is free.
- Output slot is free when !event_valid || event_ready. In a free cycle:
  - If any pending bit is set: grant the first set bit searching last_grant+1 upward, wrapping modulo N_INPUTS. Then event_valid<=1, event_id<=grant, pending[grant]<=0, last_grant<=grant.
  - Otherwise: event_valid<=0.
- Back-to-back: an accepted event with another channel pending produces the next event on the next cycle with no bubble.
- Stall: while event_valid && !event_ready, event_valid and event_id hold; pending flags keep accumulating.
- Edge collisions:
  - New rising edge on channel i in the same cycle pending[i] is being granted: pending[i] stays 1 (set wins); overflow unaffected.
  - New rising edge while pending[i]=1 and not being granted: overflow[i]<=1 and the event is lost.
- overflow clearing: overflow_clr[i] clears overflow[i]. A simultaneous overflow set on the same bit wins over clear.
- Reset mid-operation (any cycle):
  - All state returns to reset values and in-flight events are discarded.
  - The debounced level restarts at 0, so an input held high through reset yields one rising-edge event after the full latency.
- No combinational path from event_ready to event_valid or event_id; both are registered.

Test Plan (N_INPUTS=4, SYNC_DEPTH=2, DEBOUNCE_CYCLES=4, rst_in high 3 cycles, inputs 0):
- Clean edge: us_in[2] 0->1 before edge E0, event_ready=1 -> level_out[2]=1 after E0+5; event_valid=1, event_id=2 after E0+7 for exactly one cycle. Driving us_in[2] back low gives level_out[2]=0 five edges later and no event.
- Bounce: us_in[1] high 3 cycles, low 1, high 2, low -> level_out stays 0, no event, overflow=0. Then high 4+ cycles -> exactly one event id=1.
- Round-robin under stall: us_in[0] and us_in[3] rise together, event_ready=0 -> event_id=0 held. Raise event_ready for 1 cycle -> next cycle event_id=3. Another ready -> event_valid=0. A repeat of both edges then grants 3 only if last_grant < 3; check the sequence 0,3 then 0,3.
- Overflow: ready=0, three debounced rising edges on channel 1 while its first event is held -> second edge re-pends (pending already set from first? no, first granted), third sets overflow[1]=1. Pulse overflow_clr[1] -> overflow[1]=0. A coincident set plus clear leaves overflow[1]=1.
- Set/grant collision: force channel 2 edge in the exact cycle pending[2] is granted -> two consecutive events id=2, overflow[2]=0.
- Reset mid-operation: with pending[0,2] set and event_valid=1, assert rst_in 1 cycle -> next cycle event_valid=0, level_out=0, overflow=0. us_in[0] held high -> one event id=0 at the full latency after reset release.
